control_pipe: RTL

//  Parametrised pipelined RV32I main decoder: decodes op/funct3/funct7b5 in Decode and carries the controls through D->E->M->W registers.

---
 rtl/control_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/control_pipe.sv
// control_pipe: pipelined RV32I main decoder with D->E->M->W control registers.
// Illegal encodings decode as write-free bubbles carrying an illegal tag.
module control_pipe #(
  parameter int ALU_CTRL_W = 4,
  parameter bit EN_JALR    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [1:0]            imm_src_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_e,
  output logic                  jalr_e,
  output logic                  pc_src_e,
  output logic                  load_e,
  output logic                  reg_write_m,
  output logic                  mem_write_m,
  output logic                  illegal_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w
);

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] res;
    logic       br;
    logic       jmp;
    logic       jalr;
    logic [3:0] alu;
    logic       src;
    logic [2:0] f3;
    logic       ill;
  } id_ex_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] res;
    logic       ill;
  } ex_mem_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] res;
  } mem_wb_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  id_ex_t     w_d;
  id_ex_t     r_e;
  ex_mem_t    r_m;
  mem_wb_t    r_w;
  logic [3:0] w_alu;
  logic       w_bad;
  logic       w_cond;

  // Shared R/I ALU selection; only R with f3=000 can pick sub
  always_comb begin
    w_alu = 4'd0;
    unique case (funct3)
      3'b000: w_alu = (op == OP_R && funct7b5) ? 4'd1 : 4'd0;
      3'b001: w_alu = 4'd7;
      3'b010: w_alu = 4'd5;
      3'b011: w_alu = 4'd6;
      3'b100: w_alu = 4'd4;
      3'b101: w_alu = funct7b5 ? 4'd9 : 4'd8;
      3'b110: w_alu = 4'd3;
      3'b111: w_alu = 4'd2;
    endcase
  end

  always_comb begin
    w_d       = '0;
    w_d.f3    = funct3;
    imm_src_d = 2'b00;
    w_bad     = 1'b0;
    unique case (op)
      OP_LW: begin
        w_d.rw  = 1'b1;
        w_d.src = 1'b1;
        w_d.res = 2'b01;
      end
      OP_SW: begin
        w_d.mw    = 1'b1;
        w_d.src   = 1'b1;
        imm_src_d = 2'b01;
      end
      OP_R, OP_I: begin
        w_d.rw  = 1'b1;
        w_d.src = (op == OP_I);
        w_d.alu = w_alu;
        if (ALU_CTRL_W < 4 && funct3 == 3'b101)
          w_bad = 1'b1;
      end
      OP_B: begin
        w_d.br    = 1'b1;
        w_d.alu   = 4'd1;
        imm_src_d = 2'b10;
        w_bad     = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        w_d.rw    = 1'b1;
        w_d.jmp   = 1'b1;
        w_d.res   = 2'b10;
        imm_src_d = 2'b11;
      end
      OP_JALR: begin
        w_d.rw   = 1'b1;
        w_d.jmp  = 1'b1;
        w_d.jalr = 1'b1;
        w_d.src  = 1'b1;
        w_d.res  = 2'b10;
        w_bad    = (funct3 != 3'b000) || !EN_JALR;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_d     = '0;
      w_d.ill = 1'b1;
    end
  end

  always_comb begin
    w_cond = 1'b0;
    unique case (r_e.f3)
      3'b000:  w_cond = zero_e;
      3'b001:  w_cond = !zero_e;
      3'b100:  w_cond = lt_e;
      3'b101:  w_cond = !lt_e;
      3'b110:  w_cond = ltu_e;
      3'b111:  w_cond = !ltu_e;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_e <= '0;
    else if (flush_e)
      r_e <= '0;
    else
      r_e <= w_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_m <= '{rw: r_e.rw, mw: r_e.mw, res: r_e.res, ill: r_e.ill};
      r_w <= '{rw: r_m.rw, res: r_m.res};
    end
  end

  assign pc_src_e      = r_e.jmp | (r_e.br & w_cond);
  assign alu_control_e = r_e.alu[ALU_CTRL_W-1:0];
  assign alu_src_e     = r_e.src;
  assign jalr_e        = r_e.jalr;
  assign load_e        = (r_e.res == 2'b01);
  assign reg_write_m   = r_m.rw;
  assign mem_write_m   = r_m.mw;
  assign illegal_m     = r_m.ill;
  assign reg_write_w   = r_w.rw;
  assign result_src_w  = r_w.res;

endmodule
